// File: rtl/router_input_arbiter_pkg.sv
// Shared router definitions used by the input arbiter.
//   - Arbiter FSM state encodings (2-bit, legacy-compatible constants)
//   - Default abort timeout for the router round-trip
//   - Held packet record and a one-hot helper
package router_input_arbiter_pkg;

  localparam int SRC_COUNT       = 4;
  localparam int TIMEOUT_DEFAULT = 16;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] dest;
  } pkt_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/router_input_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker.
//   request : per-source request bits
//   ptr     : highest-priority source this round
//   found   : at least one request is set
//   index   : first set request scanning ptr, ptr+1, ... (mod 4)
module rr_pick4 (
  input  logic [3:0] request,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] index
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    found = 1'b0;
    index = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (request[ptr + 2'(k)]) begin
        found = 1'b1;
        index = ptr + 2'(k);
      end
    end
  end

endmodule

// File: rtl/router_input_arbiter.sv
// Round-robin arbiter feeding one router input port from four sources.
// One packet is outstanding at a time; the arbiter waits for the router to
// drop and then re-raise rtr_ready_in before arbitrating again, and aborts
// with a timeout_err pulse if either wait exceeds TIMEOUT cycles.
//   clk, rst        : clock, asynchronous active-high reset
//   src_valid/data/dest : per-source request, byte, destination
//   src_ack         : one-hot pulse, source's packet taken
//   rtr_ready_in    : router input-ready
//   rtr_pkt_valid, rtr_data_in, rtr_dest_addr : packet to router
//   busy, grant_id, timeout_err, pkt_count    : status
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | waiting for router ready and any source request
// ISSUE     | one-cycle strobe to router, ack to the winner
// WAIT_ACK  | waiting for router to drop ready (packet accepted)
// WAIT_DONE | waiting for router to raise ready again
module router_input_arbiter
  import router_input_arbiter_pkg::*;
#(
  parameter int NUM_SRC = SRC_COUNT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [8*NUM_SRC-1:0]   src_data,
  input  logic [2*NUM_SRC-1:0]   src_dest,
  output logic [NUM_SRC-1:0]     src_ack,
  input  logic                   rtr_ready_in,
  output logic                   rtr_pkt_valid,
  output logic [7:0]             rtr_data_in,
  output logic [1:0]             rtr_dest_addr,
  output logic                   busy,
  output logic [1:0]             grant_id,
  output logic                   timeout_err,
  output logic [15:0]            pkt_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [1:0]    rr_ptr;
  logic [TW-1:0] timer;
  logic          timer_tc;
  logic          abort;
  pkt_t          hold;
  logic          pick_found;
  logic [1:0]    pick_idx;

  rr_pick4 u_pick (
    .request (src_valid),
    .ptr     (rr_ptr),
    .found   (pick_found),
    .index   (pick_idx)
  );

  assign timer_tc = (timer == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    case (state)
      ST_IDLE:      if (rtr_ready_in && pick_found) state_nxt = ST_ISSUE;
      ST_ISSUE:     state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (!rtr_ready_in) begin
          state_nxt = ST_WAIT_DONE;
        end else if (timer_tc) begin
          state_nxt = ST_IDLE;
          abort     = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (rtr_ready_in) begin
          state_nxt = ST_IDLE;
        end else if (timer_tc) begin
          state_nxt = ST_IDLE;
          abort     = 1'b1;
        end
      end
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= 2'd0;
      grant_id    <= 2'd0;
      hold        <= '0;
      timer       <= '0;
      timeout_err <= 1'b0;
      pkt_count   <= 16'd0;
    end else begin
      state       <= state_nxt;
      timeout_err <= abort;

      // Timer only runs while dwelling in one of the two wait states.
      if ((state_nxt != state) ||
          !((state == ST_WAIT_ACK) || (state == ST_WAIT_DONE))) begin
        timer <= '0;
      end else begin
        timer <= timer + TW'(1);
      end

      if ((state == ST_IDLE) && (state_nxt == ST_ISSUE)) begin
        grant_id  <= pick_idx;
        hold.data <= src_data[{pick_idx, 3'b000} +: 8];
        hold.dest <= src_dest[{pick_idx, 1'b0} +: 2];
      end

      if (state == ST_ISSUE) begin
        rr_ptr    <= grant_id + 2'd1;
        pkt_count <= pkt_count + 16'd1;
      end
    end
  end

  assign rtr_pkt_valid = (state == ST_ISSUE);
  assign src_ack       = (state == ST_ISSUE) ? onehot4(grant_id) : 4'b0000;
  assign busy          = (state != ST_IDLE);
  assign rtr_data_in   = hold.data;
  assign rtr_dest_addr = hold.dest;

endmodule

// File: tb/tb_router_input_arbiter.sv
module tb_router_input_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  src_valid = '0;
  logic [31:0] src_data = '0;
  logic [7:0]  src_dest = '0;
  logic [3:0]  src_ack;
  logic        rtr_ready_in = 1'b0;
  logic        rtr_pkt_valid;
  logic [7:0]  rtr_data_in;
  logic [1:0]  rtr_dest_addr;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;
  logic [15:0] pkt_count;

  int checks = 0;
  int errors = 0;

  // Reference model: pending requests, per-source payload, pointer, count.
  logic [3:0] pending = '0;
  logic [7:0] mdata [4];
  logic [1:0] mdest [4];
  int         exp_ptr = 0;
  int         exp_count = 0;

  router_input_arbiter #(.NUM_SRC(4), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .src_valid     (src_valid),
    .src_data      (src_data),
    .src_dest      (src_dest),
    .src_ack       (src_ack),
    .rtr_ready_in  (rtr_ready_in),
    .rtr_pkt_valid (rtr_pkt_valid),
    .rtr_data_in   (rtr_data_in),
    .rtr_dest_addr (rtr_dest_addr),
    .busy          (busy),
    .grant_id      (grant_id),
    .timeout_err   (timeout_err),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;

  // Strobe/ack invariant checked every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (($countones(src_ack) > 1) || ((src_ack != 4'b0) != rtr_pkt_valid)) begin
        errors++;
        $display("FAIL ack_strobe_rule src_ack=%b rtr_pkt_valid=%b", src_ack, rtr_pkt_valid);
      end
    end
  end

  function automatic int model_pick(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sources();
    src_valid = pending;
    for (int i = 0; i < 4; i++) begin
      src_data[8*i +: 8] = mdata[i];
      src_dest[2*i +: 2] = mdest[i];
    end
  endtask

  // From IDLE: present requests with router ready, advance into ISSUE, capture.
  task automatic issue_and_capture(output logic [3:0] ack, output logic [7:0] d,
                                   output logic [1:0] dst, output logic [1:0] g,
                                   output logic strobe);
    drive_sources();
    rtr_ready_in = 1'b1;
    step();
    ack = src_ack; d = rtr_data_in; dst = rtr_dest_addr; g = grant_id; strobe = rtr_pkt_valid;
  endtask

  // From ISSUE: router keeps ready r1 extra cycles, drops it for 1+r2, then raises it.
  task automatic finish_packet(input int r1, input int r2);
    step();
    for (int i = 0; i < r1; i++) step();
    rtr_ready_in = 1'b0;
    step();
    for (int i = 0; i < r2; i++) step();
    rtr_ready_in = 1'b1;
    step();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_ptr = 0;
    exp_count = 0;
  endtask

  task automatic test_reset();
    pending = '0;
    drive_sources();
    rtr_ready_in = 1'b0;
    rst = 1'b1;
    step();
    checks++; if (src_ack !== 4'b0)       begin errors++; $display("FAIL reset_src_ack got=%b want=0", src_ack); end
    checks++; if (rtr_pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_pkt_valid got=%b want=0", rtr_pkt_valid); end
    checks++; if (rtr_data_in !== 8'h00)  begin errors++; $display("FAIL reset_data got=%h want=00", rtr_data_in); end
    checks++; if (rtr_dest_addr !== 2'd0) begin errors++; $display("FAIL reset_dest got=%0d want=0", rtr_dest_addr); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (grant_id !== 2'd0)      begin errors++; $display("FAIL reset_grant got=%0d want=0", grant_id); end
    checks++; if (timeout_err !== 1'b0)   begin errors++; $display("FAIL reset_timeout got=%b want=0", timeout_err); end
    checks++; if (pkt_count !== 16'd0)    begin errors++; $display("FAIL reset_count got=%0d want=0", pkt_count); end
    rst = 1'b0;
    exp_ptr = 0;
    exp_count = 0;
  endtask

  task automatic test_single();
    logic [3:0] ack; logic [7:0] d; logic [1:0] dst; logic [1:0] g; logic s;
    pending = 4'b0001; mdata[0] = 8'hA5; mdest[0] = 2'd2;
    issue_and_capture(ack, d, dst, g, s);
    checks++; if (s !== 1'b1)         begin errors++; $display("FAIL single_strobe got=%b want=1", s); end
    checks++; if (ack !== 4'b0001)    begin errors++; $display("FAIL single_ack got=%b want=0001", ack); end
    checks++; if (d !== 8'hA5)        begin errors++; $display("FAIL single_data got=%h want=a5", d); end
    checks++; if (dst !== 2'd2)       begin errors++; $display("FAIL single_dest got=%0d want=2", dst); end
    checks++; if ((4'b0001 << dst) !== 4'b0100) begin errors++; $display("FAIL single_valid_out got=%b want=0100", 4'b0001 << dst); end
    pending = 4'b0000; drive_sources();
    exp_ptr = 1; exp_count = 1;
    finish_packet(0, 1);
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL single_count got=%0d want=1", pkt_count); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL single_idle got=%b want=0", busy); end
    checks++; if (rtr_data_in !== 8'hA5) begin errors++; $display("FAIL single_hold got=%h want=a5", rtr_data_in); end
  endtask

  task automatic test_ready_block();
    logic [3:0] ack; logic [7:0] d; logic [1:0] dst; logic [1:0] g; logic s;
    int w;
    pending = 4'b0010; mdata[1] = 8'h3C; mdest[1] = 2'd1;
    drive_sources();
    rtr_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || rtr_data_in !== 8'hA5 || grant_id !== 2'd0) begin
        errors++;
        $display("FAIL ready_block busy=%b data=%h grant=%0d want 0/a5/0", busy, rtr_data_in, grant_id);
      end
    end
    w = model_pick(pending, exp_ptr);
    issue_and_capture(ack, d, dst, g, s);
    checks++; if (g !== 2'(w) || d !== mdata[w]) begin errors++; $display("FAIL ready_release grant=%0d data=%h want %0d/%h", g, d, w, mdata[w]); end
    pending[w] = 1'b0; drive_sources();
    exp_ptr = (w + 1) % 4; exp_count++;
    finish_packet(1, 1);
  endtask

  task automatic test_rotation();
    logic [3:0] ack; logic [7:0] d; logic [1:0] dst; logic [1:0] g; logic s;
    int order [5] = '{0, 1, 2, 3, 0};
    int tally [4] = '{0, 0, 0, 0};
    apply_reset();
    for (int i = 0; i < 4; i++) begin mdata[i] = 8'(8'h10 + i); mdest[i] = 2'(3 - i); end
    pending = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      issue_and_capture(ack, d, dst, g, s);
      checks++;
      if (g !== 2'(order[n]) || ack !== (4'b0001 << order[n]) || d !== mdata[order[n]]) begin
        errors++;
        $display("FAIL rotation n=%0d grant=%0d ack=%b data=%h want %0d", n, g, ack, d, order[n]);
      end
      if (n < 4) tally[g]++;
      // Source re-requests immediately with a new payload.
      mdata[g] = mdata[g] + 8'h40;
      drive_sources();
      exp_ptr = (int'(g) + 1) % 4; exp_count++;
      finish_packet(0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tally[i] != 1) begin errors++; $display("FAIL rotation_once src=%0d acks=%0d want=1", i, tally[i]); end
    end
    pending = 4'b0000; drive_sources();
  endtask

  task automatic test_random();
    logic [3:0] ack; logic [7:0] d; logic [1:0] dst; logic [1:0] g; logic s;
    int w;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pending[i] && $urandom_range(1, 0) == 1) begin
          pending[i] = 1'b1;
          mdata[i] = 8'($urandom);
          mdest[i] = 2'($urandom);
        end else if (pending[i] && $urandom_range(7, 0) == 0) begin
          pending[i] = 1'b0;  // withdrawn before being granted
        end
      end
      if (pending == 4'b0) begin
        drive_sources();
        rtr_ready_in = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL random_noreq busy=%b want=0", busy); end
        continue;
      end
      w = model_pick(pending, exp_ptr);
      issue_and_capture(ack, d, dst, g, s);
      checks++;
      if (s !== 1'b1 || ack !== (4'b0001 << w) || g !== 2'(w) || d !== mdata[w] || dst !== mdest[w]) begin
        errors++;
        $display("FAIL random_pkt n=%0d strobe=%b ack=%b grant=%0d data=%h dest=%0d want ack=%b grant=%0d data=%h dest=%0d",
                 n, s, ack, g, d, dst, 4'b0001 << w, w, mdata[w], mdest[w]);
      end
      pending[w] = 1'b0;
      drive_sources();
      exp_ptr = (w + 1) % 4;
      exp_count++;
      finish_packet($urandom_range(4, 0), $urandom_range(4, 0));
      checks++;
      if (busy !== 1'b0 || pkt_count !== 16'(exp_count)) begin
        errors++;
        $display("FAIL random_done n=%0d busy=%b count=%0d want 0/%0d", n, busy, pkt_count, exp_count);
      end
    end
    pending = 4'b0000; drive_sources();
  endtask

  task automatic test_done_stall();
    logic [3:0] ack; logic [7:0] d; logic [1:0] dst; logic [1:0] g; logic s;
    int w;
    pending = 4'b0100; mdata[2] = 8'h5A; mdest[2] = 2'd1;
    w = model_pick(pending, exp_ptr);
    issue_and_capture(ack, d, dst, g, s);
    pending = 4'b0000; drive_sources();
    exp_ptr = (w + 1) % 4; exp_count++;
    rtr_ready_in = 1'b0;
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (busy !== 1'b1 || rtr_pkt_valid !== 1'b0 || timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold i=%0d busy=%b strobe=%b terr=%b want 1/0/0", i, busy, rtr_pkt_valid, timeout_err);
      end
      if (i < 9) step();
    end
    rtr_ready_in = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b0 || pkt_count !== 16'(exp_count)) begin
      errors++;
      $display("FAIL stall_release busy=%b terr=%b count=%0d want 0/0/%0d", busy, timeout_err, pkt_count, exp_count);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] ack; logic [7:0] d; logic [1:0] dst; logic [1:0] g; logic s;
    int w, n;
    // Router never drops ready: abort from WAIT_ACK.
    pending = 4'b0001; mdata[0] = 8'hC3; mdest[0] = 2'd3;
    w = model_pick(pending, exp_ptr);
    issue_and_capture(ack, d, dst, g, s);
    pending = 4'b0000; drive_sources();
    exp_ptr = (w + 1) % 4; exp_count++;
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (timeout_err === 1'b1) break;
    end
    checks++; if (n != TIMEOUT + 1) begin errors++; $display("FAIL timeout_ack cycles=%0d want=%0d", n, TIMEOUT + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_ack_idle busy=%b want=0", busy); end
    step();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_pulse got=%b want=0", timeout_err); end
    // Router drops ready and never returns: abort from WAIT_DONE.
    pending = 4'b0010; mdata[1] = 8'h77; mdest[1] = 2'd0;
    w = model_pick(pending, exp_ptr);
    issue_and_capture(ack, d, dst, g, s);
    checks++; if (g !== 2'(w)) begin errors++; $display("FAIL timeout_grant got=%0d want=%0d", g, w); end
    pending = 4'b0000; drive_sources();
    exp_ptr = (w + 1) % 4; exp_count++;
    rtr_ready_in = 1'b0;
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (timeout_err === 1'b1) break;
    end
    checks++; if (n != TIMEOUT + 2) begin errors++; $display("FAIL timeout_done cycles=%0d want=%0d", n, TIMEOUT + 2); end
    checks++; if (pkt_count !== 16'(exp_count)) begin errors++; $display("FAIL timeout_count got=%0d want=%0d", pkt_count, exp_count); end
    rtr_ready_in = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    logic [3:0] ack; logic [7:0] d; logic [1:0] dst; logic [1:0] g; logic s;
    pending = 4'b0010; mdata[1] = 8'hE1; mdest[1] = 2'd3;
    issue_and_capture(ack, d, dst, g, s);
    pending = 4'b0000; drive_sources();
    rtr_ready_in = 1'b0;
    step();
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_pre busy=%b want=1", busy); end
    rst = 1'b1;
    #1;
    checks++;
    if (src_ack !== 4'b0 || rtr_pkt_valid !== 1'b0 || rtr_data_in !== 8'h00 || rtr_dest_addr !== 2'd0 ||
        busy !== 1'b0 || grant_id !== 2'd0 || timeout_err !== 1'b0 || pkt_count !== 16'd0) begin
      errors++;
      $display("FAIL midreset_outputs ack=%b v=%b d=%h a=%0d busy=%b g=%0d terr=%b cnt=%0d want all 0",
               src_ack, rtr_pkt_valid, rtr_data_in, rtr_dest_addr, busy, grant_id, timeout_err, pkt_count);
    end
    step();
    rst = 1'b0;
    exp_ptr = 0; exp_count = 0;
    rtr_ready_in = 1'b1;
    pending = 4'b1000; mdata[3] = 8'h9B; mdest[3] = 2'd2;
    issue_and_capture(ack, d, dst, g, s);
    checks++;
    if (g !== 2'd3 || ack !== 4'b1000 || d !== 8'h9B) begin
      errors++;
      $display("FAIL midreset_grant grant=%0d ack=%b data=%h want 3/1000/9b", g, ack, d);
    end
    pending = 4'b0000; drive_sources();
    exp_ptr = 0; exp_count = 1;
    finish_packet(0, 0);
  endtask

  task automatic test_wrap();
    logic [3:0] ack; logic [7:0] d; logic [1:0] dst; logic [1:0] g; logic s;
    force dut.pkt_count = 16'hFFFF;
    #1;
    release dut.pkt_count;
    exp_count = 65535;
    checks++; if (pkt_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got=%h want=ffff", pkt_count); end
    pending = 4'b0001; mdata[0] = 8'h01; mdest[0] = 2'd0;
    issue_and_capture(ack, d, dst, g, s);
    pending = 4'b0000; drive_sources();
    exp_count = (exp_count + 1) % 65536;
    finish_packet(0, 0);
    checks++; if (pkt_count !== 16'(exp_count)) begin errors++; $display("FAIL wrap_count got=%h want=%h", pkt_count, 16'(exp_count)); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin mdata[i] = '0; mdest[i] = '0; end
    test_reset();
    test_single();
    test_ready_block();
    test_rotation();
    test_random();
    test_done_stall();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_input_arbiter.md
ROUTER_INPUT_ARBITER -- requirements
Module: router_input_arbiter

Interface
REQ-001 Parameter NUM_SRC, 4, number of requesting sources (fixed at 4; one per router destination-address width).
REQ-002 Parameter TIMEOUT, 16, maximum cycles spent in WAIT_ACK or WAIT_DONE before abort.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 src_valid  input  4  per-source packet request; bit i = source i.
REQ-006 src_data  input  32  per-source byte; source i on bits [8i+7:8i].
REQ-007 src_dest  input  8  per-source destination; source i on bits [2i+1:2i].
REQ-008 src_ack  output  4  one-hot pulse: source i's packet taken.
REQ-009 rtr_ready_in  input  1  router input-ready.
REQ-010 rtr_pkt_valid  output  1  packet strobe to router.
REQ-011 rtr_data_in  output  8  byte to router.
REQ-012 rtr_dest_addr  output  2  destination to router.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 grant_id  output  2  index of the most recent winner.
REQ-015 timeout_err  output  1  one-cycle pulse on abort.
REQ-016 pkt_count  output  16  packets issued since reset, wraps 0xFFFF->0x0000.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE; all outputs Moore, decoded from registers.
REQ-018 IDLE: when rtr_ready_in=1 and src_valid!=0, winner = first set bit scanning rr_ptr, rr_ptr+1, ... mod 4; latch its data/dest into hold regs, grant_id<=winner, go ISSUE; otherwise stay IDLE.
REQ-019 ISSUE lasts exactly one cycle: rtr_pkt_valid=1, src_ack[grant_id]=1, rtr_data_in/rtr_dest_addr = hold regs; rr_ptr<=grant_id+1 mod 4; pkt_count increments; next state WAIT_ACK.
REQ-020 rtr_data_in/rtr_dest_addr hold their latched values in all states until the next grant.
REQ-021 WAIT_ACK: rtr_ready_in=0 -> WAIT_DONE; else if timer reaches TIMEOUT-1 -> IDLE with timeout_err pulse.
REQ-022 WAIT_DONE: rtr_ready_in=1 -> IDLE; else same timeout rule as WAIT_ACK.
REQ-023 Timer clears on every state change and counts cycles spent in WAIT_ACK/WAIT_DONE.
REQ-024 Sources hold valid/data/dest stable from assertion until src_ack; a source dropping valid before ack is not granted and no packet is lost or duplicated.
REQ-025 Only one packet outstanding; no new arbitration until return to IDLE; minimum packet spacing is the router round-trip.
REQ-026 Source with src_valid held high for multiple packets is served at most once per rotation while others request (no starvation).
REQ-027 rtr_ready_in=0 in IDLE blocks arbitration; hold regs unchanged.
REQ-028 src_ack and rtr_pkt_valid never assert outside ISSUE; src_ack always one-hot or zero.

Reset
REQ-029 rst asserted at any time, including mid-packet, forces IDLE immediately: src_ack=0, rtr_pkt_valid=0, rtr_data_in=0, rtr_dest_addr=0, busy=0, grant_id=0, timeout_err=0, pkt_count=0, rr_ptr=0, timer=0.
REQ-030 First arbitration after reset release favours source 0.

Structure
REQ-031 State encodings (IDLE=0, ISSUE=1, WAIT_ACK=2, WAIT_DONE=3) and TIMEOUT default belong in the shared router package alongside the router's own state constants.
REQ-032 Round-robin priority selection is one sub-module, rr_pick4 (inputs request[3:0], ptr[1:0]; outputs found, index[1:0]), purely combinational.

Verification
REQ-033 Reset, src_valid=0001, data0=0xA5, dest0=2, router idle -> one-cycle rtr_pkt_valid with 0xA5/2, src_ack=0001, router valid_out=0100, pkt_count=1.
REQ-034 src_valid=1111 held continuously, distinct data -> grant order 0,1,2,3,0; each src_ack exactly once per rotation.
REQ-035 Router ready_out[dest]=0 for 10 cycles -> arbiter remains in WAIT_DONE, busy=1, no second strobe; completes on release.
REQ-036 rtr_ready_in forced 1 after ISSUE -> timeout_err pulse after TIMEOUT cycles in WAIT_ACK, return IDLE.
REQ-037 rst asserted during WAIT_DONE -> all outputs zero same cycle; post-release src_valid=1000 -> grant_id=3.
REQ-038 Preload pkt_count path with 65535 issues -> next issue wraps to 0.
